// File: rtl/csr_trap_unit_if.sv
// CSR access port between the execute stage and the machine-mode CSR file.
// The master drives address/op/data; the CSR file returns the old value and an illegal flag.
interface csr_trap_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic [11:0]     csr_addr;
    logic [1:0]      csr_op;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;
    logic            illegal_csr_o;

    modport master (
        output csr_addr,
        output csr_op,
        output csr_wdata,
        input  csr_rdata,
        input  illegal_csr_o
    );

    modport slave (
        input  csr_addr,
        input  csr_op,
        input  csr_wdata,
        output csr_rdata,
        output illegal_csr_o
    );
endinterface

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file for the 3-stage RV32 pipeline: CSR access, mcycle/minstret counters,
// IRQ synchronisation, interrupt entry with vector computation, and mret handling.
module csr_trap_unit #(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     COUNTER_W   = 64,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0,
    parameter bit              VECTORED_EN = 1'b1,
    parameter int unsigned     SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    csr_trap_unit_if.slave  csr,
    input  logic [XLEN-1:0] pc_i,
    input  logic            inst_retire_i,
    input  logic            mret_i,
    input  logic            irq_timer_i,
    input  logic            irq_ext_i,
    output logic            trap_taken_o,
    output logic [XLEN-1:0] trap_vec_o,
    output logic [XLEN-1:0] epc_o
);

    localparam logic [11:0] CsrMstatus   = 12'h300;
    localparam logic [11:0] CsrMie       = 12'h304;
    localparam logic [11:0] CsrMtvec     = 12'h305;
    localparam logic [11:0] CsrMepc      = 12'h341;
    localparam logic [11:0] CsrMcause    = 12'h342;
    localparam logic [11:0] CsrMip       = 12'h344;
    localparam logic [11:0] CsrMcycle    = 12'hB00;
    localparam logic [11:0] CsrMinstret  = 12'hB02;
    localparam logic [11:0] CsrMcycleh   = 12'hB80;
    localparam logic [11:0] CsrMinstreth = 12'hB82;

    localparam logic [COUNTER_W-1:0] CntOne = {{(COUNTER_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        OpNone = 2'b00,
        OpRw   = 2'b01,
        OpRs   = 2'b10,
        OpRc   = 2'b11
    } csr_op_e;

    // Architectural state
    logic                 mstatus_mie_q, mstatus_mie_d;
    logic                 mstatus_mpie_q, mstatus_mpie_d;
    logic                 mie_mtie_q, mie_mtie_d;
    logic                 mie_meie_q, mie_meie_d;
    logic [XLEN-1:2]      mtvec_base_q, mtvec_base_d;
    logic                 mtvec_mode_q, mtvec_mode_d;
    logic [XLEN-1:2]      mepc_q, mepc_d;
    logic [XLEN-1:0]      mcause_q, mcause_d;
    logic [COUNTER_W-1:0] mcycle_q, mcycle_d;
    logic [COUNTER_W-1:0] minstret_q, minstret_d;
    logic [SYNC_STAGES-1:0] timer_sync_q;
    logic [SYNC_STAGES-1:0] ext_sync_q;

    csr_op_e         op;
    logic            mip_mtip, mip_meip;
    logic            pend_timer, pend_ext;
    logic [3:0]      trap_code;
    logic [XLEN-1:0] vec_off;
    logic [XLEN-1:0] rdata;
    logic [XLEN-1:0] wval;
    logic            implemented, read_only, is_write, illegal, csr_we;
    logic [2*XLEN-1:0] mcycle_ext, minstret_ext;

    // PC is word aligned in mepc; the two LSBs are never stored.
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^pc_i[1:0];

    assign op       = csr_op_e'(csr.csr_op);
    assign mip_mtip = timer_sync_q[SYNC_STAGES-1];
    assign mip_meip = ext_sync_q[SYNC_STAGES-1];

    always_comb begin
        mcycle_ext                  = '0;
        minstret_ext                = '0;
        mcycle_ext[COUNTER_W-1:0]   = mcycle_q;
        minstret_ext[COUNTER_W-1:0] = minstret_q;
    end

    // Combinational read mux; also classifies the address.
    always_comb begin
        rdata       = '0;
        implemented = 1'b1;
        read_only   = 1'b0;
        case (csr.csr_addr)
            CsrMstatus: begin
                rdata[3] = mstatus_mie_q;
                rdata[7] = mstatus_mpie_q;
            end
            CsrMie: begin
                rdata[7]  = mie_mtie_q;
                rdata[11] = mie_meie_q;
            end
            CsrMip: begin
                rdata[7]  = mip_mtip;
                rdata[11] = mip_meip;
                read_only = 1'b1;
            end
            CsrMtvec:     rdata = {mtvec_base_q, 1'b0, mtvec_mode_q};
            CsrMepc:      rdata = {mepc_q, 2'b00};
            CsrMcause:    rdata = mcause_q;
            CsrMcycle:    rdata = mcycle_ext[XLEN-1:0];
            CsrMcycleh:   rdata = mcycle_ext[2*XLEN-1:XLEN];
            CsrMinstret:  rdata = minstret_ext[XLEN-1:0];
            CsrMinstreth: rdata = minstret_ext[2*XLEN-1:XLEN];
            default:      implemented = 1'b0;
        endcase
    end

    // RS/RC with a zero mask are pure reads and so are legal on read-only CSRs.
    assign is_write = (op == OpRw) || (csr.csr_wdata != '0);
    assign illegal  = (op != OpNone) && (!implemented || (read_only && is_write));
    assign csr_we   = (op != OpNone) && is_write && !illegal && !trap_taken_o;

    always_comb begin
        wval = csr.csr_wdata;
        unique case (op)
            OpRs:    wval = rdata | csr.csr_wdata;
            OpRc:    wval = rdata & ~csr.csr_wdata;
            default: wval = csr.csr_wdata;
        endcase
    end

    assign csr.csr_rdata     = rdata;
    assign csr.illegal_csr_o = illegal;

    // Interrupt decision; external wins over timer.
    assign pend_timer   = mip_mtip & mie_mtie_q;
    assign pend_ext     = mip_meip & mie_meie_q;
    assign trap_taken_o = mstatus_mie_q & (pend_timer | pend_ext) & ~mret_i;
    assign trap_code    = pend_ext ? 4'd11 : 4'd7;

    always_comb begin
        vec_off = '0;
        if (mtvec_mode_q) begin
            vec_off[5:0] = {trap_code, 2'b00};
        end
    end

    assign trap_vec_o = {mtvec_base_q, 2'b00} + vec_off;
    assign epc_o      = {mepc_q, 2'b00};

    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_mtie_d     = mie_mtie_q;
        mie_meie_d     = mie_meie_q;
        mtvec_base_d   = mtvec_base_q;
        mtvec_mode_d   = mtvec_mode_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mcycle_d       = mcycle_q + CntOne;
        minstret_d     = inst_retire_i ? (minstret_q + CntOne) : minstret_q;

        if (trap_taken_o) begin
            mepc_d              = pc_i[XLEN-1:2];
            mcause_d            = '0;
            mcause_d[XLEN-1]    = 1'b1;
            mcause_d[3:0]       = trap_code;
            mstatus_mpie_d      = mstatus_mie_q;
            mstatus_mie_d       = 1'b0;
        end else if (csr_we) begin
            // A write to either counter half replaces it and suppresses that cycle's increment.
            case (csr.csr_addr)
                CsrMstatus: begin
                    mstatus_mie_d  = wval[3];
                    mstatus_mpie_d = wval[7];
                end
                CsrMie: begin
                    mie_mtie_d = wval[7];
                    mie_meie_d = wval[11];
                end
                CsrMtvec: begin
                    mtvec_base_d = wval[XLEN-1:2];
                    mtvec_mode_d = VECTORED_EN & wval[0];
                end
                CsrMepc:      mepc_d   = wval[XLEN-1:2];
                CsrMcause:    mcause_d = wval;
                CsrMcycle:    mcycle_d = {mcycle_q[COUNTER_W-1:XLEN], wval};
                CsrMcycleh:   mcycle_d = {wval[COUNTER_W-XLEN-1:0], mcycle_q[XLEN-1:0]};
                CsrMinstret:  minstret_d = {minstret_q[COUNTER_W-1:XLEN], wval};
                CsrMinstreth: minstret_d = {wval[COUNTER_W-XLEN-1:0], minstret_q[XLEN-1:0]};
                default: ;
            endcase
        end

        if (mret_i) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_mtie_q     <= 1'b0;
            mie_meie_q     <= 1'b0;
            mtvec_base_q   <= MTVEC_RESET[XLEN-1:2];
            mtvec_mode_q   <= VECTORED_EN & MTVEC_RESET[0];
            mepc_q         <= '0;
            mcause_q       <= '0;
            mcycle_q       <= '0;
            minstret_q     <= '0;
            timer_sync_q   <= '0;
            ext_sync_q     <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_mtie_q     <= mie_mtie_d;
            mie_meie_q     <= mie_meie_d;
            mtvec_base_q   <= mtvec_base_d;
            mtvec_mode_q   <= mtvec_mode_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mcycle_q       <= mcycle_d;
            minstret_q     <= minstret_d;
            timer_sync_q   <= {timer_sync_q[SYNC_STAGES-2:0], irq_timer_i};
            ext_sync_q     <= {ext_sync_q[SYNC_STAGES-2:0], irq_ext_i};
        end
    end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Bench for csr_trap_unit: table of CSR accesses, hand-written trap/mret/counter/reset
// sequences, then a randomized run compared against a CSR-level reference model.
module tb_csr_trap_unit;
    localparam int unsigned XLEN      = 32;
    localparam logic [31:0] MTVEC_RST = 32'h0000_0400;
    localparam int unsigned SYNC      = 2;
    localparam int          NRAND     = 3000;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic        retire, mret, tirq, eirq;
    logic        trap_taken;
    logic [31:0] trap_vec, epc;

    int errors = 0;
    int checks = 0;

    csr_trap_unit_if #(.XLEN(XLEN)) bus ();

    csr_trap_unit #(
        .XLEN        (XLEN),
        .COUNTER_W   (64),
        .MTVEC_RESET (MTVEC_RST),
        .VECTORED_EN (1'b1),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .csr           (bus),
        .pc_i          (pc),
        .inst_retire_i (retire),
        .mret_i        (mret),
        .irq_timer_i   (tirq),
        .irq_ext_i     (eirq),
        .trap_taken_o  (trap_taken),
        .trap_vec_o    (trap_vec),
        .epc_o         (epc)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [11:0] addr;
        logic [1:0]  op;
        logic [31:0] wdata;
        logic [31:0] exp_old;
        logic        exp_ill;
        logic [31:0] exp_new;
    } vec_t;

    vec_t tbl[13];

    // Reference model state
    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause;
    logic [63:0] m_cycle, m_instret;
    logic        tq[$];
    logic        eq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h required %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd);
        bus.csr_addr  = a;
        bus.csr_op    = op;
        bus.csr_wdata = wd;
    endtask

    task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
        drive(a, 2'b00, 32'h0);
        #1;
        check(name, bus.csr_rdata, exp);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        drive(12'h000, 2'b00, 32'h0);
        pc     = 32'h0;
        retire = 1'b0;
        mret   = 1'b0;
        tirq   = 1'b0;
        eirq   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic m_impl(input logic [11:0] a);
        case (a)
            12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344,
            12'hB00, 12'hB80, 12'hB02, 12'hB82: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h304: return m_mie;
            12'h344: return (tq[0] ? 32'h80 : 32'h0) | (eq[0] ? 32'h800 : 32'h0);
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'hB00: return m_cycle[31:0];
            12'hB80: return m_cycle[63:32];
            12'hB02: return m_instret[31:0];
            12'hB82: return m_instret[63:32];
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_mstatus = 32'h0;
        m_mie     = 32'h0;
        m_mtvec   = MTVEC_RST & 32'hFFFF_FFFD;
        m_mepc    = 32'h0;
        m_mcause  = 32'h0;
        m_cycle   = 64'h0;
        m_instret = 64'h0;
        tq.delete();
        eq.delete();
        for (int i = 0; i < SYNC; i++) begin
            tq.push_back(1'b0);
            eq.push_back(1'b0);
        end
    endtask

    // One randomized cycle: drive at negedge, compare, advance the model, cross the posedge.
    task automatic step(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd,
                        input logic ret, input logic mr, input logic ti, input logic ei,
                        input logic [31:0] pcv);
        logic [31:0] old, nv, pend, code, off, vec;
        logic        isw, ill, trap;
        logic [63:0] cyc_n, ins_n;
        drive(a, op, wd);
        pc     = pcv;
        retire = ret;
        mret   = mr;
        tirq   = ti;
        eirq   = ei;
        #1;
        old  = m_read(a);
        isw  = (op == 2'b01) || (wd != 32'h0);
        ill  = (op != 2'b00) && (!m_impl(a) || (a == 12'h344 && isw));
        pend = m_read(12'h344) & m_mie;
        trap = m_mstatus[3] && (pend != 32'h0) && !mr;
        code = pend[11] ? 32'd11 : 32'd7;
        off  = (m_mtvec[1:0] == 2'b01) ? code * 4 : 32'h0;
        vec  = {m_mtvec[31:2], 2'b00} + off;
        check("rnd_rdata", bus.csr_rdata, old);
        check("rnd_illegal", 32'(bus.illegal_csr_o), 32'(ill));
        check("rnd_trap_taken", 32'(trap_taken), 32'(trap));
        check("rnd_trap_vec", trap_vec, vec);
        check("rnd_epc", epc, m_mepc);

        case (op)
            2'b01:   nv = wd;
            2'b10:   nv = old | wd;
            default: nv = old & ~wd;
        endcase
        cyc_n = m_cycle + 64'd1;
        ins_n = m_instret + {63'd0, ret};
        if (trap) begin
            m_mepc    = pcv & 32'hFFFF_FFFC;
            m_mcause  = 32'h8000_0000 | code;
            m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
        end else if (op != 2'b00 && isw && !ill) begin
            case (a)
                12'h300: m_mstatus = nv & 32'h88;
                12'h304: m_mie     = nv & 32'h880;
                12'h305: m_mtvec   = nv & 32'hFFFF_FFFD;
                12'h341: m_mepc    = nv & 32'hFFFF_FFFC;
                12'h342: m_mcause  = nv;
                12'hB00: cyc_n = {m_cycle[63:32], nv};
                12'hB80: cyc_n = {nv, m_cycle[31:0]};
                12'hB02: ins_n = {m_instret[63:32], nv};
                12'hB82: ins_n = {nv, m_instret[31:0]};
                default: ;
            endcase
        end
        if (mr) m_mstatus = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
        m_cycle   = cyc_n;
        m_instret = ins_n;
        @(posedge clk);
        tq.push_back(ti);
        void'(tq.pop_front());
        eq.push_back(ei);
        void'(eq.pop_front());
        @(negedge clk);
    endtask

    initial begin
        logic [11:0] addrs [12];
        logic [11:0] ra;
        logic [1:0]  rop;
        logic [31:0] rwd;
        logic        rmr, rti, rei;

        tbl[0]  = '{12'h304, 2'b01, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 32'h0000_0880};
        tbl[1]  = '{12'h300, 2'b10, 32'h0000_0008, 32'h0000_0000, 1'b0, 32'h0000_0008};
        tbl[2]  = '{12'h300, 2'b11, 32'h0000_0008, 32'h0000_0008, 1'b0, 32'h0000_0000};
        tbl[3]  = '{12'h344, 2'b01, 32'h0000_0001, 32'h0000_0000, 1'b1, 32'h0000_0000};
        tbl[4]  = '{12'h7C0, 2'b01, 32'h0000_0005, 32'h0000_0000, 1'b1, 32'h0000_0000};
        tbl[5]  = '{12'h344, 2'b10, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000};
        tbl[6]  = '{12'h305, 2'b01, 32'h0000_1003, 32'h0000_0400, 1'b0, 32'h0000_1001};
        tbl[7]  = '{12'h341, 2'b01, 32'h0000_1237, 32'h0000_0000, 1'b0, 32'h0000_1234};
        tbl[8]  = '{12'h342, 2'b01, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
        tbl[9]  = '{12'h304, 2'b11, 32'h0000_0080, 32'h0000_0880, 1'b0, 32'h0000_0800};
        tbl[10] = '{12'h300, 2'b01, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 32'h0000_0088};
        tbl[11] = '{12'h300, 2'b01, 32'h0000_0000, 32'h0000_0088, 1'b0, 32'h0000_0000};
        tbl[12] = '{12'h7C0, 2'b10, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000};

        // Reset state and first-cycle counter value
        do_reset();
        rd("rst_mcycle", 12'hB00, 32'h0);
        rd("rst_mstatus", 12'h300, 32'h0);
        rd("rst_mie", 12'h304, 32'h0);
        rd("rst_mcause", 12'h342, 32'h0);
        rd("rst_mtvec", 12'h305, MTVEC_RST);
        check("rst_trap", 32'(trap_taken), 32'h0);
        check("rst_epc", epc, 32'h0);
        check("rst_illegal", 32'(bus.illegal_csr_o), 32'h0);
        @(negedge clk);
        rd("mcycle_2nd", 12'hB00, 32'h1);

        // Table of single CSR accesses
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(tbl[i].addr, tbl[i].op, tbl[i].wdata);
            #1;
            check($sformatf("tbl%0d_old", i), bus.csr_rdata, tbl[i].exp_old);
            check($sformatf("tbl%0d_illegal", i), 32'(bus.illegal_csr_o), 32'(tbl[i].exp_ill));
            @(negedge clk);
            rd($sformatf("tbl%0d_new", i), tbl[i].addr, tbl[i].exp_new);
        end

        // Timer interrupt entry through the synchroniser
        @(negedge clk);
        drive(12'h304, 2'b01, 32'h0000_0880);
        @(negedge clk);
        drive(12'h300, 2'b01, 32'h0000_0008);
        tirq = 1'b1;
        pc   = 32'h0000_2468;
        #1;
        check("tmr_trap_c0", 32'(trap_taken), 32'h0);
        @(negedge clk);
        drive(12'h000, 2'b00, 32'h0);
        #1;
        check("tmr_trap_c1", 32'(trap_taken), 32'h0);
        @(negedge clk);
        #1;
        check("tmr_trap_c2", 32'(trap_taken), 32'h1);
        check("tmr_vec", trap_vec, 32'h0000_101C);
        @(negedge clk);
        rd("tmr_mepc", 12'h341, 32'h0000_2468);
        rd("tmr_mcause", 12'h342, 32'h8000_0007);
        rd("tmr_mstatus", 12'h300, 32'h0000_0080);
        check("tmr_trap_after", 32'(trap_taken), 32'h0);

        // External beats timer; mret returns and the trap fires again
        eirq = 1'b1;
        repeat (2) @(negedge clk);
        drive(12'h300, 2'b10, 32'h0000_0008);
        #1;
        check("ext_rs_old", bus.csr_rdata, 32'h0000_0080);
        check("ext_trap_pre", 32'(trap_taken), 32'h0);
        @(negedge clk);
        drive(12'h000, 2'b00, 32'h0);
        pc = 32'h0000_3000;
        #1;
        check("ext_trap", 32'(trap_taken), 32'h1);
        check("ext_vec", trap_vec, 32'h0000_102C);
        @(negedge clk);
        rd("ext_mcause", 12'h342, 32'h8000_000B);
        rd("ext_mstatus", 12'h300, 32'h0000_0080);
        rd("ext_mepc", 12'h341, 32'h0000_3000);
        mret = 1'b1;
        #1;
        check("mret_epc", epc, 32'h0000_3000);
        check("mret_trap", 32'(trap_taken), 32'h0);
        @(negedge clk);
        mret = 1'b0;
        rd("mret_mstatus", 12'h300, 32'h0000_0088);
        check("mret_retake", 32'(trap_taken), 32'h1);
        mret = 1'b1;
        #1;
        check("mret_pending_block", 32'(trap_taken), 32'h0);
        @(negedge clk);
        mret = 1'b0;
        #1;
        check("mret_after_trap", 32'(trap_taken), 32'h1);
        check("mret_after_vec", trap_vec, 32'h0000_102C);

        // Asynchronous reset in the middle of a trap cycle
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_trap", 32'(trap_taken), 32'h0);
        check("arst_epc", epc, 32'h0);
        rd("arst_mepc", 12'h341, 32'h0);
        rd("arst_mcause", 12'h342, 32'h0);
        rd("arst_mtvec", 12'h305, MTVEC_RST);
        @(posedge clk);
        @(negedge clk);
        tirq  = 1'b0;
        eirq  = 1'b0;
        rst_n = 1'b1;
        drive(12'h304, 2'b01, 32'h0000_0880);
        #1;
        check("post_rst_old", bus.csr_rdata, 32'h0);
        check("post_rst_illegal", 32'(bus.illegal_csr_o), 32'h0);
        @(negedge clk);
        rd("post_rst_mie", 12'h304, 32'h0000_0880);
        check("post_rst_trap", 32'(trap_taken), 32'h0);

        // Counter carry and wrap
        @(negedge clk);
        drive(12'hB80, 2'b01, 32'h0);
        @(negedge clk);
        drive(12'hB00, 2'b01, 32'hFFFF_FFFF);
        @(negedge clk);
        rd("cyc_lo_held", 12'hB00, 32'hFFFF_FFFF);
        rd("cyc_hi_held", 12'hB80, 32'h0);
        @(negedge clk);
        rd("cyc_lo_carry", 12'hB00, 32'h0);
        rd("cyc_hi_carry", 12'hB80, 32'h1);
        drive(12'hB82, 2'b01, 32'hFFFF_FFFF);
        @(negedge clk);
        drive(12'hB02, 2'b01, 32'hFFFF_FFFF);
        retire = 1'b1;
        @(negedge clk);
        rd("ins_lo_held", 12'hB02, 32'hFFFF_FFFF);
        rd("ins_hi_held", 12'hB82, 32'hFFFF_FFFF);
        @(negedge clk);
        retire = 1'b0;
        rd("ins_lo_wrap", 12'hB02, 32'h0);
        rd("ins_hi_wrap", 12'hB82, 32'h0);
        @(negedge clk);
        rd("ins_no_retire", 12'hB02, 32'h0);

        // Randomized run against the model
        do_reset();
        model_reset();
        addrs = '{12'h300, 12'h304, 12'h344, 12'h305, 12'h341, 12'h342,
                  12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h7C0, 12'h301};
        rti = 1'b0;
        rei = 1'b0;
        for (int n = 0; n < NRAND; n++) begin
            ra  = addrs[$urandom_range(0, 11)];
            rop = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       rwd = 32'h0;
                1:       rwd = $urandom & 32'h0000_0888;
                default: rwd = $urandom;
            endcase
            rmr = ($urandom_range(0, 99) < 8);
            if (rmr) rop = 2'b00;
            if ($urandom_range(0, 9) == 0) rti = ~rti;
            if ($urandom_range(0, 9) == 0) rei = ~rei;
            step(ra, rop, rwd, 1'($urandom_range(0, 1)), rmr, rti, rei, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
